// File: rtl/hand_shake_pkg.sv
// Shared definitions for the multi-channel handshake receiver: channel state
// encoding, the channel-index width helper and the default synchroniser depth.
package hand_shake_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFull = 2'd1,
    StAck  = 2'd2
  } ch_state_e;

  localparam int unsigned DefSyncStages = 2;

  // Index width that stays at least one bit wide for a single channel.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hand_shake_rx_ch.sv
// One four-phase receive channel: req synchroniser, capture register, state machine and
// registered ack. Optional sticky protocol-error flag under HSRX_PROTO_CHK_EN.
module hand_shake_rx_ch
  import hand_shake_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned SyncStages = DefSyncStages
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 xfer_i,
  output logic                 full_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 ack_o
`ifdef HSRX_PROTO_CHK_EN
  ,
  output logic                 err_o
`endif
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  req_s;
  ch_state_e             state_q, state_d;
  logic [DataWidth-1:0]  data_q, data_d;
  logic                  ack_q, ack_d;

  // req_i is foreign-domain; only the last synchroniser stage is used by logic.
  assign sync_d = {sync_q[SyncStages-2:0], req_i};
  assign req_s  = sync_q[SyncStages-1];

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_s) begin
          data_d  = data_i;
          state_d = StFull;
        end
      end
      StFull: begin
        if (xfer_i) begin
          state_d = StAck;
        end
      end
      StAck: begin
        // Ack follows the seen req, so a req dropped early never produces an ack pulse.
        if (req_s) begin
          ack_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      state_q <= StIdle;
      data_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
    end
  end

  assign full_o = (state_q == StFull);
  assign data_o = data_q;
  assign ack_o  = ack_q;

`ifdef HSRX_PROTO_CHK_EN
  logic err_q, err_d;

  assign err_d = err_q | ((state_q == StFull) && !req_s);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: rtl/hand_shake_rx_mc.sv
// Multi-channel handshake receiver: CH_NUM channels merged onto one valid/ready stream by a
// round-robin arbiter with grant lock. HSRX_PROTO_CHK_EN adds the sticky oErr flags.
module hand_shake_rx_mc
  import hand_shake_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH  = 32,
  parameter int unsigned  CH_NUM      = 4,
  parameter int unsigned  SYNC_STAGES = DefSyncStages,
  localparam int unsigned CH_IDX_W    = idx_width(CH_NUM)
) (
  input  logic                         iRxClk,
  input  logic                         iRstnRx,
  input  logic [CH_NUM-1:0]            iTxRdy,
  input  logic [CH_NUM*DATA_WIDTH-1:0] iData,
  output logic [CH_NUM-1:0]            oRxAck,
  output logic                         oValid,
  input  logic                         iReady,
  output logic [DATA_WIDTH-1:0]        oData,
  output logic [CH_IDX_W-1:0]          oChId
`ifdef HSRX_PROTO_CHK_EN
  ,
  output logic [CH_NUM-1:0]            oErr
`endif
);

  logic [CH_NUM-1:0]     full;
  logic [CH_NUM-1:0]     xfer;
  logic [DATA_WIDTH-1:0] ch_data [CH_NUM];

  logic [CH_IDX_W-1:0]   ptr_q, ptr_d;
  logic                  lock_q, lock_d;
  logic [CH_IDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic [CH_IDX_W-1:0]   rr_grant, grant;
  logic [CH_IDX_W:0]     cand_sum;
  logic [CH_IDX_W-1:0]   cand;
  logic                  found;
  logic                  transfer;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    hand_shake_rx_ch #(
      .DataWidth (DATA_WIDTH),
      .SyncStages(SYNC_STAGES)
    ) u_ch (
      .clk_i (iRxClk),
      .rst_ni(iRstnRx),
      .req_i (iTxRdy[c]),
      .data_i(iData[c*DATA_WIDTH +: DATA_WIDTH]),
      .xfer_i(xfer[c]),
      .full_o(full[c]),
      .data_o(ch_data[c]),
      .ack_o (oRxAck[c])
`ifdef HSRX_PROTO_CHK_EN
      ,
      .err_o (oErr[c])
`endif
    );
  end

  // First FULL channel at or after the pointer, wrapping modulo CH_NUM.
  always_comb begin
    rr_grant = '0;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      cand_sum = {1'b0, ptr_q} + (CH_IDX_W+1)'(i);
      if (cand_sum >= (CH_IDX_W+1)'(CH_NUM)) begin
        cand_sum = cand_sum - (CH_IDX_W+1)'(CH_NUM);
      end
      cand = cand_sum[CH_IDX_W-1:0];
      if (!found && full[cand]) begin
        found    = 1'b1;
        rr_grant = cand;
      end
    end
  end

  // A stalled offer keeps its grant, so late arrivals cannot change oData/oChId.
  assign grant    = lock_q ? lock_idx_q : rr_grant;
  assign oValid   = |full;
  assign transfer = oValid & iReady;
  assign oData    = ch_data[grant];
  assign oChId    = grant;

  always_comb begin
    xfer       = '0;
    ptr_d      = ptr_q;
    lock_d     = oValid & ~iReady;
    lock_idx_d = grant;
    if (transfer) begin
      xfer[grant] = 1'b1;
      ptr_d       = (grant == CH_IDX_W'(CH_NUM - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge iRxClk or negedge iRstnRx) begin
    if (!iRstnRx) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: tb/tb_hand_shake_rx_mc.sv
// Scoreboard bench for hand_shake_rx_mc: directed handshakes push expected words, a monitor
// pops and compares on every accepted output word.
module tb_hand_shake_rx_mc;

  localparam int DW = 32;
  localparam int CN = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CN-1:0]    tx_rdy;
  logic [CN*DW-1:0] data_in;
  logic [CN-1:0]    rx_ack;
  logic             valid;
  logic             ready;
  logic [DW-1:0]    data_out;
  logic [IW-1:0]    ch_id;
`ifdef HSRX_PROTO_CHK_EN
  logic [CN-1:0]    err;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [IW+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  hand_shake_rx_mc #(
    .DATA_WIDTH (DW),
    .CH_NUM     (CN),
    .SYNC_STAGES(2)
  ) dut (
    .iRxClk (clk),
    .iRstnRx(rst_n),
    .iTxRdy (tx_rdy),
    .iData  (data_in),
    .oRxAck (rx_ack),
    .oValid (valid),
    .iReady (ready),
    .oData  (data_out),
    .oChId  (ch_id)
`ifdef HSRX_PROTO_CHK_EN
    ,
    .oErr   (err)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic raise(input int c, input logic [DW-1:0] d);
    data_in[c*DW +: DW] = d;
    tx_rdy[c] = 1'b1;
  endtask

  task automatic expect_word(input int c, input logic [DW-1:0] d);
    exp_q.push_back({IW'(c), d});
  endtask

  task automatic wait_ack(input int c, input logic lvl);
    int k = 0;
    while (rx_ack[c] !== lvl && k < 20) begin
      step();
      k++;
    end
    if (rx_ack[c] !== lvl) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout ch%0d: got %b expected %b", c, rx_ack[c], lvl);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      step();
      k++;
    end
    check("drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    tx_rdy = '0;
    ready  = 1'b0;
    rst_n  = 1'b0;
    step(2);
    rst_n  = 1'b1;
    step(1);
  endtask

  // Monitor: an accepted word is one seen with valid & ready away from the clock edge.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got ch%0d %h expected none", ch_id, data_out);
      end else begin
        logic [IW+DW-1:0] e;
        e = exp_q.pop_front();
        check("word", 64'({ch_id, data_out}), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    tx_rdy  = '0;
    data_in = '0;
    ready   = 1'b0;
    step(2);
    check("rst_ack", 64'(rx_ack), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_chid", 64'(ch_id), 64'd0);
`ifdef HSRX_PROTO_CHK_EN
    check("rst_err", 64'(err), 64'd0);
`endif
    rst_n = 1'b1;
    step(1);

    // Single capture with exact latencies.
    ready = 1'b1;
    raise(0, 32'hDEAD_BEEF);
    expect_word(0, 32'hDEAD_BEEF);
    step(2);
    check("t1_valid_early", 64'(valid), 64'd0);
    step(1);
    check("t1_valid", 64'(valid), 64'd1);
    check("t1_chid", 64'(ch_id), 64'd0);
    check("t1_data", 64'(data_out), 64'hDEAD_BEEF);
    step(1);
    check("t1_ack_wait", 64'(rx_ack[0]), 64'd0);
    check("t1_valid_gone", 64'(valid), 64'd0);
    step(1);
    check("t1_ack", 64'(rx_ack[0]), 64'd1);
    tx_rdy[0] = 1'b0;
    step(2);
    check("t1_ack_hold", 64'(rx_ack[0]), 64'd1);
    step(1);
    check("t1_ack_rel", 64'(rx_ack[0]), 64'd0);

    // Backpressure on ch2.
    ready = 1'b0;
    raise(2, 32'h2222_0002);
    expect_word(2, 32'h2222_0002);
    step(3);
    for (int i = 0; i < 10; i++) begin
      check("t2_valid", 64'(valid), 64'd1);
      check("t2_data", 64'(data_out), 64'h2222_0002);
      check("t2_chid", 64'(ch_id), 64'd2);
      check("t2_ack_low", 64'(rx_ack[2]), 64'd0);
      step(1);
    end
    ready = 1'b1;
    step(1);
    check("t2_ack_wait", 64'(rx_ack[2]), 64'd0);
    step(1);
    check("t2_ack", 64'(rx_ack[2]), 64'd1);
    tx_rdy[2] = 1'b0;
    wait_ack(2, 1'b0);

    // Fairness: all four captured together from pointer 0, one word per cycle.
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < CN; c++) begin
      raise(c, 32'hA000_0000 + 32'(c));
      expect_word(c, 32'hA000_0000 + 32'(c));
    end
    step(3);
    for (int i = 0; i < CN; i++) begin
      check("t3_valid", 64'(valid), 64'd1);
      check("t3_chid", 64'(ch_id), 64'(i));
      step(1);
    end
    check("t3_empty", 64'(valid), 64'd0);
    for (int c = 0; c < CN; c++) wait_ack(c, 1'b1);
    tx_rdy = '0;
    for (int c = 0; c < CN; c++) wait_ack(c, 1'b0);
    // Pointer moves past ch2, so a later 0/1/3 batch is served 3,0,1.
    raise(2, 32'hB000_0002);
    expect_word(2, 32'hB000_0002);
    wait_ack(2, 1'b1);
    tx_rdy[2] = 1'b0;
    wait_ack(2, 1'b0);
    expect_word(3, 32'hC000_0003);
    expect_word(0, 32'hC000_0000);
    expect_word(1, 32'hC000_0001);
    raise(0, 32'hC000_0000);
    raise(1, 32'hC000_0001);
    raise(3, 32'hC000_0003);
    wait_ack(0, 1'b1);
    wait_ack(1, 1'b1);
    wait_ack(3, 1'b1);
    tx_rdy = '0;
    for (int c = 0; c < CN; c++) wait_ack(c, 1'b0);
    drain();

    // Grant lock: ch3 stalled, ch0 arrives later with pointer at 0.
    do_reset();
    raise(3, 32'h3333_0003);
    expect_word(3, 32'h3333_0003);
    step(3);
    check("t4_valid", 64'(valid), 64'd1);
    check("t4_chid", 64'(ch_id), 64'd3);
    raise(0, 32'h0000_C0C0);
    expect_word(0, 32'h0000_C0C0);
    step(4);
    for (int i = 0; i < 3; i++) begin
      check("t4_lock_chid", 64'(ch_id), 64'd3);
      check("t4_lock_data", 64'(data_out), 64'h3333_0003);
      step(1);
    end
    ready = 1'b1;
    step(1);
    check("t4_next_valid", 64'(valid), 64'd1);
    check("t4_next_chid", 64'(ch_id), 64'd0);
    wait_ack(3, 1'b1);
    wait_ack(0, 1'b1);
    tx_rdy = '0;
    wait_ack(3, 1'b0);
    wait_ack(0, 1'b0);
    drain();

    // Req withdrawn while FULL: word still delivered, no ack pulse.
    ready = 1'b0;
    raise(1, 32'h5151_0001);
    expect_word(1, 32'h5151_0001);
    step(3);
    check("t5_valid", 64'(valid), 64'd1);
    tx_rdy[1] = 1'b0;
    step(3);
    check("t5_still_valid", 64'(valid), 64'd1);
    check("t5_chid", 64'(ch_id), 64'd1);
`ifdef HSRX_PROTO_CHK_EN
    check("t5_err_set", 64'(err), 64'b0010);
`endif
    ready = 1'b1;
    step(1);
    check("t5_ack0", 64'(rx_ack[1]), 64'd0);
    check("t5_valid_gone", 64'(valid), 64'd0);
    step(2);
    check("t5_ack1", 64'(rx_ack[1]), 64'd0);
`ifdef HSRX_PROTO_CHK_EN
    check("t5_err_sticky", 64'(err), 64'b0010);
`endif
    drain();
    do_reset();
`ifdef HSRX_PROTO_CHK_EN
    check("t5_err_clear", 64'(err), 64'd0);
`endif

    // Asynchronous reset while ch0 sits in ACK; the held req is delivered again once.
    ready = 1'b1;
    raise(0, 32'h6060_0006);
    expect_word(0, 32'h6060_0006);
    wait_ack(0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_ack_async", 64'(rx_ack), 64'd0);
    check("t6_valid_async", 64'(valid), 64'd0);
    step(2);
    expect_word(0, 32'h6060_0006);
    rst_n = 1'b1;
    wait_ack(0, 1'b1);
    tx_rdy[0] = 1'b0;
    wait_ack(0, 1'b0);
    step(5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hand_shake_rx_mc.md
# hand_shake_rx_mc

Multi-channel, parametrised successor to the single-channel full-handshake receiver. Terminates `CH_NUM` independent four-phase req/ack links arriving from foreign clock domains, each with a `SYNC_STAGES`-deep synchroniser and a per-channel capture register. Captured words are merged onto one valid/ready stream through a round-robin arbiter. The block adds downstream backpressure: a channel's ack is not raised until its word has been accepted downstream. It sits at the receive-domain boundary, ahead of any local FIFO or consumer.

## Interface
- `DATA_WIDTH`, 32, payload width per channel.
- `CH_NUM`, 4, number of handshake channels (1..16).
- `SYNC_STAGES`, 2, synchroniser flops on each `iTxRdy` (≥2).
- `CH_IDX_W`, localparam, `max(1, clog2(CH_NUM))`.

Ports:
- `iRxClk`  in  1  receive clock; the only clock.
- `iRstnRx`  in  1  reset, asynchronous, active-low.
- `iTxRdy`  in  `CH_NUM`  per-channel request (asynchronous to `iRxClk`).
- `iData`  in  `CH_NUM*DATA_WIDTH`  channel c occupies bits `[c*DATA_WIDTH +: DATA_WIDTH]`; held stable by the source while its req is high.
- `oRxAck`  out  `CH_NUM`  per-channel acknowledge, registered.
- `oValid`  out  1  merged output word valid.
- `iReady`  in  1  downstream accepts.
- `oData`  out  `DATA_WIDTH`  merged word.
- `oChId`  out  `CH_IDX_W`  source channel of `oData`.
- `oErr`  out  `CH_NUM`  sticky protocol-error flags; present only with `HSRX_PROTO_CHK_EN`.

## Operation
Per channel, a 3-state FSM runs on the synchronised req `rReqS[c]`:
- **IDLE:**
  - If `rReqS` = 1, latch `iData` slice into the channel data register and go to FULL.
  - Ack stays 0.
- **FULL:**
  - Word is offered to the arbiter.
  - On transfer (granted and `oValid & iReady`), go to ACK; `oRxAck[c]` is set next edge.
- **ACK:**
  - `oRxAck[c]` = 1.
  - If `rReqS` = 0, clear ack and go to IDLE.

Arbiter:
- `oValid` = OR of FULL channels.
- Grant goes to the first FULL channel at or after pointer `rPtr`, wrapping modulo `CH_NUM`.
- `oData`/`oChId` are muxed from the granted channel.
- On each transfer, `rPtr` ← granted index + 1, wrapping `CH_NUM-1` → 0.
- Stability: while `oValid & !iReady`, the grant is locked in a register, so `oData`/`oChId` must not change until the transfer, even if other channels become FULL.
- `CH_NUM` = 1: arbiter degenerates; `oChId` is always 0.

## Timing
- Reset values:
  - `oRxAck` = 0, `oValid` = 0, `oData` = 0, `oChId` = 0, `oErr` = 0.
  - All FSMs in IDLE, `rPtr` = 0, data registers = 0, synchronisers = 0.
- Capture latency: `iTxRdy` rise → FULL / `oValid` after `SYNC_STAGES`+1 edges.
- Transfer at edge T → `oRxAck[c]` high after T+1.
- Ack release latency: `iTxRdy` fall → `oRxAck` low after `SYNC_STAGES`+1 edges.
- Ack never rises before the word is accepted; ack never falls while req is seen high.
- Each channel holds at most one word; there is no internal queueing.
- Simultaneous events:
  - Several channels reaching FULL on the same edge are served in pointer order, one per `iReady` cycle.
  - With `iReady` held 1, the merged output sustains one word per cycle.
- Reset mid-operation: all state is discarded and acks drop asynchronously. A req still high after reset is re-captured (duplicate delivery); sources must restart their handshake after reset.

## Configuration
`HSRX_PROTO_CHK_EN`:
- **Defined:**
  - The `oErr` port exists.
  - `oErr[c]` sets, sticky until reset, when `rReqS[c]` falls while channel c is FULL (req withdrawn before ack).
  - The word is still delivered. The channel then passes through ACK for one cycle and returns to IDLE.
- **Undefined:**
  - No `oErr` port and no check logic.
  - The same req drop is silently tolerated with identical data-path behaviour.

## Structure
- Shared package `hand_shake_pkg`: channel state encoding (IDLE=0, FULL=1, ACK=2), the `clog2`-based index-width function, and the default `SYNC_STAGES`.
- Sub-module `hand_shake_rx_ch`: one channel (synchroniser, FSM, data register, ack flop, optional error flag), instantiated `CH_NUM` times via generate.
- The arbiter and grant lock live in the top.

## Test plan
- **Single capture:** ch0 req high with data 0xDEADBEEF, `iReady`=1 → `oValid` with `oChId`=0 and `oData`=0xDEADBEEF after 3 cycles; `oRxAck[0]` high the next cycle; req low → ack low 3 cycles later.
- **Backpressure:** ch2 captured, `iReady`=0 for 10 cycles → `oValid`/`oData`/`oChId`=2 stable throughout and `oRxAck[2]`=0; `iReady`=1 → ack rises after 1 cycle.
- **Fairness:** all 4 channels held FULL continuously, `iReady`=1 → `oChId` sequence 0,1,2,3,0,1… with no channel skipped.
- **Grant lock:** ch3 valid with `iReady`=0, then ch0 becomes FULL → `oChId` remains 3 until transfer, then 0.
- **Protocol check** (macro defined): ch1 req dropped while FULL → `oErr[1]`=1, word still delivered, `oErr` persists until reset; with the macro undefined, same data sequence and no `oErr` port.
- **Async reset mid-handshake:** reset asserted with ch0 in ACK → `oRxAck` and `oValid` go 0 immediately; req still high after release → word re-delivered once.
